// File: rtl/ballot_pkg.sv
// Shared types and constants for the ballot input block: FSM states,
// candidate indices and counter widths.
package ballot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_RELEASE = 3'd3,
      ST_CLOSED  = 3'd4
   } state_t;

   localparam logic [1:0] CAND_A = 2'd0;
   localparam logic [1:0] CAND_B = 2'd1;
   localparam logic [1:0] CAND_C = 2'd2;

   localparam int                     VOTER_CNT_W   = 7;
   localparam logic [VOTER_CNT_W-1:0] VOTER_CNT_MAX = '1;

   // Only meaningful for a one-hot press vector; callers check that first.
   function automatic logic [1:0] press_to_cand(input logic [2:0] press);
      logic [1:0] cand;
      cand = CAND_A;
      if (press[CAND_B]) cand = CAND_B;
      if (press[CAND_C]) cand = CAND_C;
      return cand;
   endfunction

endpackage

// File: rtl/ballot_input_btn_debounce.sv
// Two-flop synchronizer plus debouncer for one active-low button; emits the
// debounced level and a one-cycle press event on each debounced 1->0 edge.
module btn_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic level,
   output logic press
);

   localparam int             CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;

   // NOTE: non-blocking assignments let the synchronizer stages shift in one
   // edge; blocking ones would collapse the chain into a single flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
         level  <= 1'b1;
         cnt_q  <= '0;
         press  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_n};
         press  <= 1'b0;
         if (sync_q[1] != level) begin
            if (cnt_q == DEB_LAST) begin
               level <= sync_q[1];
               cnt_q <= '0;
               press <= ~sync_q[1];
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: rtl/ballot_input.sv
// Voting-booth front end: debounced candidate buttons, voter admission FSM and
// registered vote strobes. Define BALLOT_TIMEOUT_EN to enable the ARMED timeout.
module ballot_input
   import ballot_pkg::*;
#(
   parameter int DEB_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   btn_a_n,
   input  logic                   btn_b_n,
   input  logic                   btn_c_n,
   input  logic                   arm,
   input  logic                   close_poll,
   output logic                   a_n,
   output logic                   b_n,
   output logic                   c_n,
   output logic                   vote_done,
   output logic                   ready,
   output logic [VOTER_CNT_W-1:0] voter_cnt,
   output logic                   timeout
);

   logic [2:0] deb_level;
   logic [2:0] press;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
      .clk(clk), .rst(rst), .btn_n(btn_a_n),
      .level(deb_level[CAND_A]), .press(press[CAND_A])
   );
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
      .clk(clk), .rst(rst), .btn_n(btn_b_n),
      .level(deb_level[CAND_B]), .press(press[CAND_B])
   );
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_c (
      .clk(clk), .rst(rst), .btn_n(btn_c_n),
      .level(deb_level[CAND_C]), .press(press[CAND_C])
   );

   state_t                   state_q, state_d;
   logic [1:0]               cand_q, cand_d;
   logic [VOTER_CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]               strobe_n_q, strobe_n_d;
   logic                     ready_q, ready_d;
   logic                     vote_done_q, vote_done_d;
   logic                     timeout_q, timeout_d;

`ifdef BALLOT_TIMEOUT_EN
   localparam int             TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      vote_done_d = 1'b0;
      timeout_d   = 1'b0;
`ifdef BALLOT_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (close_poll) begin
               state_d     = ST_CLOSED;
               vote_done_d = 1'b1;
            end else if (arm) begin
               state_d = ST_ARMED;
`ifdef BALLOT_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end
         end
         ST_ARMED: begin
            // Simultaneous presses are ambiguous and are dropped.
            if ($onehot(press)) begin
               state_d = ST_STROBE;
               cand_d  = press_to_cand(press);
               cnt_d   = (cnt_q == VOTER_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
`ifdef BALLOT_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         ST_STROBE:  state_d = ST_RELEASE;
         ST_RELEASE: if (&deb_level) state_d = ST_IDLE;
         ST_CLOSED:  if (!close_poll) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // Outputs are computed from the next state so they register alongside it.
      strobe_n_d = 3'b111;
      if (state_d == ST_STROBE) strobe_n_d[cand_d] = 1'b0;
      ready_d = (state_d == ST_ARMED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cand_q      <= CAND_A;
         cnt_q       <= '0;
         strobe_n_q  <= 3'b111;
         ready_q     <= 1'b0;
         vote_done_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         strobe_n_q  <= strobe_n_d;
         ready_q     <= ready_d;
         vote_done_q <= vote_done_d;
         timeout_q   <= timeout_d;
      end
   end

`ifdef BALLOT_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
   end
`endif

   assign a_n       = strobe_n_q[CAND_A];
   assign b_n       = strobe_n_q[CAND_B];
   assign c_n       = strobe_n_q[CAND_C];
   assign ready     = ready_q;
   assign vote_done = vote_done_q;
   assign voter_cnt = cnt_q;
`ifdef BALLOT_TIMEOUT_EN
   assign timeout   = timeout_q;
`else
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ballot_input.sv
// Directed self-checking bench for ballot_input (DEB_CYCLES=16,
// TIMEOUT_CYCLES=1024); timeout behaviour depends on BALLOT_TIMEOUT_EN.
module tb_ballot_input;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_a_n = 1'b1, btn_b_n = 1'b1, btn_c_n = 1'b1;
   logic       arm = 1'b0, close_poll = 1'b0;
   logic       a_n, b_n, c_n, vote_done, ready, timeout;
   logic [6:0] voter_cnt;

   int total = 0;
   int bad   = 0;
   int a_low = 0, b_low = 0, c_low = 0, vd_cnt = 0, to_cnt = 0;

   always #5 clk = ~clk;

   ballot_input #(.DEB_CYCLES(16), .TIMEOUT_CYCLES(1024)) dut (
      .clk(clk), .rst(rst),
      .btn_a_n(btn_a_n), .btn_b_n(btn_b_n), .btn_c_n(btn_c_n),
      .arm(arm), .close_poll(close_poll),
      .a_n(a_n), .b_n(b_n), .c_n(c_n),
      .vote_done(vote_done), .ready(ready),
      .voter_cnt(voter_cnt), .timeout(timeout)
   );

   // Running tallies of output activity, sampled away from the rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (a_n === 1'b0) a_low++;
         if (b_n === 1'b0) b_low++;
         if (c_n === 1'b0) c_low++;
         if (vote_done === 1'b1) vd_cnt++;
         if (timeout === 1'b1) to_cnt++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive_btn(input int idx, input logic val);
      case (idx)
         0:       btn_a_n = val;
         1:       btn_b_n = val;
         default: btn_c_n = val;
      endcase
   endtask

   task automatic do_vote(input int idx);
      arm = 1'b1; tick(1); arm = 1'b0;
      drive_btn(idx, 1'b0); tick(20);
      drive_btn(idx, 1'b1); tick(22);
   endtask

   int a0, b0, c0, v0, t0, n;

   initial begin
      // Reset state
      tick(3);
      check("rst_a_n", a_n, 1);
      check("rst_b_n", b_n, 1);
      check("rst_c_n", c_n, 1);
      check("rst_vote_done", vote_done, 0);
      check("rst_ready", ready, 0);
      check("rst_timeout", timeout, 0);
      check("rst_voter_cnt", voter_cnt, 0);
      rst = 1'b0;
      tick(3);

      // Single vote for B
      a0 = a_low; b0 = b_low; c0 = c_low;
      arm = 1'b1; tick(1); arm = 1'b0;
      check("armed_ready", ready, 1);
      btn_b_n = 1'b0; tick(20); btn_b_n = 1'b1; tick(25);
      check("b_pulse_len", b_low - b0, 1);
      check("b_no_a", a_low - a0, 0);
      check("b_no_c", c_low - c0, 0);
      check("b_cnt", voter_cnt, 1);
      check("b_back_idle", ready, 0);

      // Short glitch on A is filtered
      arm = 1'b1; tick(1); arm = 1'b0;
      a0 = a_low; b0 = b_low; c0 = c_low;
      btn_a_n = 1'b0; tick(10); btn_a_n = 1'b1; tick(30);
      check("glitch_no_strobe", (a_low - a0) + (b_low - b0) + (c_low - c0), 0);
      check("glitch_ready", ready, 1);

      // Simultaneous A+C ignored, then C alone accepted
      btn_a_n = 1'b0; btn_c_n = 1'b0; tick(25);
      check("dual_no_strobe", (a_low - a0) + (c_low - c0), 0);
      check("dual_ready", ready, 1);
      btn_a_n = 1'b1; btn_c_n = 1'b1; tick(25);
      check("dual_rel_ready", ready, 1);
      btn_c_n = 1'b0; tick(20); btn_c_n = 1'b1; tick(25);
      check("c_pulse_len", c_low - c0, 1);
      check("c_no_a", a_low - a0, 0);
      check("c_cnt", voter_cnt, 2);

      // Held button through a second arm pulse
      b0 = b_low;
      arm = 1'b1; tick(1); arm = 1'b0;
      btn_b_n = 1'b0; tick(22);
      arm = 1'b1; tick(1); arm = 1'b0; tick(30);
      check("held_one_vote", b_low - b0, 1);
      check("held_arm_ignored", ready, 0);
      btn_b_n = 1'b1; tick(25);
      check("held_released_idle", ready, 0);
      check("held_cnt", voter_cnt, 3);
      do_vote(1);
      check("revote_pulse", b_low - b0, 2);
      check("revote_cnt", voter_cnt, 4);

      // Votes 5..128: counter saturates at 127, strobes still issue
      a0 = a_low; b0 = b_low; c0 = c_low;
      for (int i = 0; i < 124; i++) do_vote(i % 3);
      check("sat_strobes", (a_low - a0) + (b_low - b0) + (c_low - c0), 124);
      check("sat_cnt", voter_cnt, 127);

      // close_poll during ARMED waits for the vote to finish
      a0 = a_low; v0 = vd_cnt;
      arm = 1'b1; tick(1); arm = 1'b0;
      close_poll = 1'b1; tick(5);
      check("close_still_armed", ready, 1);
      check("close_no_done_yet", vd_cnt - v0, 0);
      btn_a_n = 1'b0; tick(20); btn_a_n = 1'b1; tick(25);
      check("close_vote_pulse", a_low - a0, 1);
      check("close_done_once", vd_cnt - v0, 1);
      tick(10);
      check("close_done_still_once", vd_cnt - v0, 1);
      check("close_not_ready", ready, 0);
      close_poll = 1'b0; tick(2);
      arm = 1'b1; tick(1); arm = 1'b0;
      check("runoff_armed", ready, 1);
      check("runoff_cnt_kept", voter_cnt, 127);

      // Asynchronous reset while a strobe is low
      btn_b_n = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (b_n === 1'b0) break;
         tick(1);
      end
      check("rst_strobe_seen", b_n, 0);
      #2 rst = 1'b1;
      #1;
      check("rst_strobe_high", b_n, 1);
      check("rst_cnt_clear", voter_cnt, 0);
      check("rst_ready_clear", ready, 0);
      btn_b_n = 1'b1; tick(3);
      rst = 1'b0; tick(3);

      // ARMED timeout (or indefinite wait when the feature is absent)
      t0 = to_cnt;
      arm = 1'b1; tick(1); arm = 1'b0;
`ifdef BALLOT_TIMEOUT_EN
      n = 0;
      for (int i = 0; i < 1100; i++) begin
         if (ready !== 1'b1) break;
         n++;
         tick(1);
      end
      check("tmo_armed_cycles", n, 1024);
      check("tmo_pulse", timeout, 1);
      check("tmo_idle", ready, 0);
      tick(1);
      check("tmo_pulse_len", to_cnt - t0, 1);
      check("tmo_pulse_end", timeout, 0);
`else
      n = 0;
      tick(1100);
      check("no_tmo_ready", ready, 1);
      check("no_tmo_pulse", to_cnt - t0, 0);
      check("no_tmo_level", timeout, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ballot_input.md
BALLOT_INPUT -- requirements
Module: ballot_input

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles needed to change a debounced button state.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum idle cycles in ARMED, used only when the timeout feature is compiled in.
REQ-003 Port clk  input  1: clock; all logic is on the rising edge.
REQ-004 Port rst  input  1: reset; asynchronous, active-high.
REQ-005 Ports btn_a_n, btn_b_n, btn_c_n  input  1 each: raw asynchronous candidate buttons, active-low.
REQ-006 Port arm  input  1: presiding-officer enable; one voter is admitted per cycle in which arm is sampled high in IDLE.
REQ-007 Port close_poll  input  1: level; requests end of polling.
REQ-008 Ports a_n, b_n, c_n  output  1 each: vote strobes to the tally; idle high, one-cycle low pulse per accepted vote.
REQ-009 Port vote_done  output  1: one-cycle high pulse when polling closes.
REQ-010 Port ready  output  1: high while a voter is admitted (ARMED).
REQ-011 Port voter_cnt  output  7: count of accepted votes.
REQ-012 Port timeout  output  1: one-cycle pulse when an admitted voter times out.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose output changes only after DEB_CYCLES consecutive cycles of a differing synchronized value.
REQ-014 A press event SHALL be a debounced 1->0 transition, valid for exactly one cycle.
REQ-015 FSM states SHALL be IDLE, ARMED, STROBE, RELEASE and CLOSED.
REQ-016 In IDLE, the FSM SHALL go to CLOSED if close_poll=1; otherwise it SHALL go to ARMED if arm=1. close_poll has priority.
REQ-017 In ARMED, exactly one press event SHALL latch that candidate and move to STROBE; two or three simultaneous events SHALL be ignored and the FSM SHALL stay in ARMED.
REQ-018 In STROBE, exactly one cycle, the latched candidate's strobe SHALL be low, voter_cnt SHALL increment (saturating at 127), and the FSM SHALL move to RELEASE.
REQ-019 In RELEASE, the FSM SHALL wait until all three debounced buttons read 1, then go to IDLE.
REQ-020 Presses in IDLE, STROBE, RELEASE or CLOSED SHALL be discarded; arm outside IDLE SHALL be ignored.
REQ-021 close_poll SHALL be honoured only in IDLE; an admitted voter always completes or times out first.
REQ-022 vote_done SHALL pulse on the cycle CLOSED is entered; CLOSED SHALL return to IDLE when close_poll=0 (run-off round); voter_cnt SHALL be retained.
REQ-023 All outputs SHALL be registered; latency from debounced press event to strobe low SHALL be 1 cycle.

Reset
REQ-024 On rst the block SHALL enter IDLE with a_n=b_n=c_n=1, vote_done=0, ready=0, timeout=0 and voter_cnt=0; synchronizers and debouncers SHALL reset to 1 (released) with counters at 0.
REQ-025 Reset mid-STROBE SHALL force the strobe high immediately, without completing the vote.

Configuration
REQ-026 With BALLOT_TIMEOUT_EN defined, ARMED with no accepted press for TIMEOUT_CYCLES cycles SHALL go to IDLE and pulse timeout, and the counter SHALL clear on entry to ARMED.
REQ-027 Without BALLOT_TIMEOUT_EN, ARMED SHALL wait indefinitely, timeout SHALL be tied 0, and no timeout counter SHALL exist.

Structure
REQ-028 Package ballot_pkg SHALL hold the FSM state enum, the candidate index constants (A=0, B=1, C=2) and the counter widths.
REQ-029 Sub-module btn_debounce (synchronizer plus debouncer, parameter DEB_CYCLES) SHALL be instantiated three times.

Verification
REQ-030 arm pulse, btn_b_n low for 20 cycles -> b_n low exactly 1 cycle, a_n=c_n=1, voter_cnt=1.
REQ-031 btn_a_n glitch low for 10 cycles (DEB_CYCLES=16) while ARMED -> no strobe, ready stays 1.
REQ-032 btn_a_n and btn_c_n fall on the same cycle -> no strobe, stays ARMED; release, then press c -> c_n pulse.
REQ-033 Button held through a second arm pulse -> no second vote until released and re-pressed; 128 votes -> voter_cnt=127.
REQ-034 close_poll=1 while ARMED -> vote completes, then vote_done pulses once; close_poll=0 -> IDLE, arm accepted.
REQ-035 BALLOT_TIMEOUT_EN, TIMEOUT_CYCLES=1024, no press -> timeout pulse at cycle 1024 and IDLE; rst during STROBE -> strobe high immediately, voter_cnt=0.
